// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin: one full-subtractor cell stepped LSB first over WIDTH cycles.
// Optional signed-overflow output ovf_o is built only when SERSUB_OVF_EN is defined.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o
`ifdef SERSUB_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
   logic             brw_q, brw_d, bout_q, bout_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic             cell_diff, cell_bout, last_bit, accept, finish;
   logic [WIDTH-1:0] res_shift;

   assign cell_diff = a_q[0] ^ b_q[0] ^ brw_q;
   assign cell_bout = (~a_q[0] & b_q[0]) | (~a_q[0] & brw_q) | (b_q[0] & brw_q);
   assign last_bit  = (cnt_q == CW'(WIDTH - 1));
   assign accept    = (state_q == IDLE) && start_i;
   assign finish    = (state_q == SHIFT) && last_bit;

   // New difference bits enter at the MSB so the word is aligned after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_shift = cell_diff;
      end else begin : g_res_wn
         assign res_shift = {cell_diff, res_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               brw_d   = bin_i;
               cnt_d   = '0;
               res_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            res_d = res_shift;
            brw_d = cell_bout;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
               diff_d  = res_shift;
               bout_d  = cell_bout;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign diff_o = diff_q;
   assign bout_o = bout_q;

`ifdef SERSUB_OVF_EN
   // Operand sign bits are shifted out during SHIFT, so keep a copy from acceptance.
   logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;

   always_comb begin
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_msb_d = a_i[WIDTH-1];
         b_msb_d = b_i[WIDTH-1];
      end
      if (finish) begin
         ovf_d = (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: arithmetic reference model for WIDTH=8 plus a WIDTH=1 instance.
// Exercises SERSUB_OVF_EN checks when that macro is defined.
module tb_serial_subtractor_ctrl;

   localparam int W = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, bin = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, bout;
   logic [7:0] diff;
   logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
   logic       busy1, done1, diff1, bout1;
`ifdef SERSUB_OVF_EN
   logic       ovf, ovf1;
`endif

   always #5 clk = ~clk;

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b), .bin_i(bin),
      .busy_o(busy), .done_o(done), .diff_o(diff), .bout_o(bout)
`ifdef SERSUB_OVF_EN
      , .ovf_o(ovf)
`endif
   );

   serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a1), .b_i(b1), .bin_i(bin1),
      .busy_o(busy1), .done_o(done1), .diff_o(diff1), .bout_o(bout1)
`ifdef SERSUB_OVF_EN
      , .ovf_o(ovf1)
`endif
   );

   // Reference arithmetic
   function automatic logic [7:0] f_diff(input logic [7:0] x, input logic [7:0] y, input logic c);
      return x - y - 8'(c);
   endfunction
   function automatic logic f_bout(input logic [7:0] x, input logic [7:0] y, input logic c);
      return {1'b0, x} < ({1'b0, y} + 9'(c));
   endfunction
   function automatic logic f_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [7:0] d;
      d = f_diff(x, y, c);
      return (x[7] != y[7]) && (d[7] != x[7]);
   endfunction

   // Timing model: an accepted request yields its result W cycles later, then one done cycle.
   int         m_left = 0;
   logic       m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_ovf = 1'b0;
   logic       p_bout = 1'b0, p_ovf = 1'b0;
   logic [7:0] m_diff = '0, p_diff = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
         m_diff <= '0; m_bout <= 1'b0; m_ovf <= 1'b0;
         p_diff <= '0; p_bout <= 1'b0; p_ovf <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_busy <= 1'b0; m_done <= 1'b1;
            m_diff <= p_diff; m_bout <= p_bout; m_ovf <= p_ovf;
         end
         m_left <= m_left - 1;
      end else if (start) begin
         m_busy <= 1'b1; m_left <= W;
         p_diff <= f_diff(a, b, bin);
         p_bout <= f_bout(a, b, bin);
         p_ovf  <= f_ovf(a, b, bin);
      end
   end

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       ov;
      int         gap;
   } lit_t;

   lit_t lit_q[$];
   lit_t lit1_q[$];
   event chk_ev;

   int checks = 0;
   int errors = 0;

   initial begin : compare
      int   busy_run, busy_run1, since_done;
      lit_t l;
      busy_run = 0; busy_run1 = 0; since_done = 0;
      forever begin
         @(negedge clk or chk_ev);
         if (!rst_n) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
               errors++;
               $display("FAIL reset_w8: busy=%b done=%b diff=%h bout=%b required all zero", busy, done, diff, bout);
            end
            checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || bout1 !== 1'b0) begin
               errors++;
               $display("FAIL reset_w1: busy=%b done=%b diff=%b bout=%b required all zero", busy1, done1, diff1, bout1);
            end
`ifdef SERSUB_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
               errors++;
               $display("FAIL reset_ovf: ovf=%b required 0", ovf);
            end
`endif
            busy_run = 0; busy_run1 = 0;
         end else begin
            checks++;
            if (busy !== m_busy || done !== m_done || diff !== m_diff || bout !== m_bout) begin
               errors++;
               $display("FAIL cycle_w8 @%0t: busy=%b done=%b diff=%h bout=%b required busy=%b done=%b diff=%h bout=%b",
                        $time, busy, done, diff, bout, m_busy, m_done, m_diff, m_bout);
            end
`ifdef SERSUB_OVF_EN
            checks++;
            if (ovf !== m_ovf) begin
               errors++;
               $display("FAIL cycle_ovf @%0t: ovf=%b required %b", $time, ovf, m_ovf);
            end
`endif
            if (busy) busy_run++;
            if (done) begin
               $display("txn w8 @%0t: diff=%h bout=%b busy_cycles=%0d", $time, diff, bout, busy_run);
               checks++;
               if (lit_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done_w8 @%0t: done=1 required 0", $time);
               end else begin
                  l = lit_q.pop_front();
                  if (diff !== l.d || bout !== l.bo || busy_run != W) begin
                     errors++;
                     $display("FAIL result_w8: diff=%h bout=%b busy_cycles=%0d required diff=%h bout=%b busy_cycles=%0d",
                              diff, bout, busy_run, l.d, l.bo, W);
                  end
                  if (l.gap != 0) begin
                     checks++;
                     if (since_done + 1 != l.gap) begin
                        errors++;
                        $display("FAIL done_gap: got %0d required %0d", since_done + 1, l.gap);
                     end
                  end
`ifdef SERSUB_OVF_EN
                  checks++;
                  if (ovf !== l.ov) begin
                     errors++;
                     $display("FAIL result_ovf: ovf=%b required %b", ovf, l.ov);
                  end
`endif
               end
               busy_run = 0; since_done = 0;
            end else begin
               since_done++;
            end

            if (busy1) busy_run1++;
            checks++;
            if (busy1 && done1) begin
               errors++;
               $display("FAIL busy_done_w1: busy=1 done=1 required exclusive");
            end
            if (done1) begin
               $display("txn w1 @%0t: diff=%b bout=%b busy_cycles=%0d", $time, diff1, bout1, busy_run1);
               checks++;
               if (lit1_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done_w1 @%0t: done=1 required 0", $time);
               end else begin
                  l = lit1_q.pop_front();
                  if (diff1 !== l.d[0] || bout1 !== l.bo || busy_run1 != 1) begin
                     errors++;
                     $display("FAIL result_w1: diff=%b bout=%b busy_cycles=%0d required diff=%b bout=%b busy_cycles=1",
                              diff1, bout1, busy_run1, l.d[0], l.bo);
                  end
               end
               busy_run1 = 0;
            end
         end
      end
   end

   task automatic wait_done();
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      if (!done) begin
         $display("FAIL timeout_w8: done never rose");
         $fatal(1);
      end
   endtask

   task automatic op(input logic [7:0] x, input logic [7:0] y, input logic c,
                     input logic [7:0] ed, input logic eb, input logic eo);
      lit_q.push_back('{ed, eb, eo, 0});
      @(negedge clk); a = x; b = y; bin = c; start = 1'b1;
      @(negedge clk); start = 1'b0; a = ~x; b = ~y; bin = ~c;
      wait_done();
      @(negedge clk);
   endtask

   task automatic op1(input logic x, input logic y, input logic c, input logic ed, input logic eb);
      lit1_q.push_back('{{7'd0, ed}, eb, 1'b0, 0});
      @(negedge clk); a1 = x; b1 = y; bin1 = c; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int i = 0; i < 10 && !done1; i++) @(negedge clk);
      if (!done1) begin
         $display("FAIL timeout_w1: done never rose");
         $fatal(1);
      end
      @(negedge clk);
   endtask

   initial begin : main
      logic [7:0] d1_tab, b1_tab;
      d1_tab = 8'b1001_0110;
      b1_tab = 8'b1000_1110;

      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
      op(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0);
      op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
      op(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0);
      op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
      op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);

      // start held high through busy and done; second request waits for IDLE
      lit_q.push_back('{8'h37, 1'b0, 1'b0, 0});
      lit_q.push_back('{8'h00, 1'b0, 1'b0, W + 2});
      @(negedge clk); a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
      @(negedge clk); a = 8'h01; b = 8'h01;
      wait_done();
      @(negedge clk);
      @(negedge clk); start = 1'b0;
      wait_done();
      @(negedge clk);

      // reset during the third SHIFT cycle
      @(negedge clk); a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 -> chk_ev;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         op1(v[2], v[1], v[0], d1_tab[i], b1_tab[i]);
      end

      repeat (3) @(negedge clk);
      if (lit_q.size() != 0 || lit1_q.size() != 0)
         $display("FAIL pending_results: %0d/%0d expected results never seen", lit_q.size(), lit1_q.size());
      $display("CHECKS %0d ERRORS %0d", checks, errors + lit_q.size() + lit1_q.size());
      $finish;
   end

endmodule
